// File: rtl/output_write_arbiter.sv
// Round-robin arbiter for the shared output memory write port.
// Ports: clock/reset_n; req_valid/req_data/req_addr in, req_ready out;
// mem_stall in; WriteBus/WriteAddress/WriteEnable out; idle; write_count.
// Optional macro WR_ARB_STATS_EN enables the write_count register.
module output_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      mem_stall,
  output logic [DATA_W-1:0]         WriteBus,
  output logic [ADDR_W-1:0]         WriteAddress,
  output logic                      WriteEnable,
  output logic                      idle,
  output logic [15:0]               write_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]   NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ-1);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      nxt_ptr;
  logic [PW:0]        sum;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_any;
  logic               slot_free;
  logic [DATA_W-1:0]  sel_data;
  logic [ADDR_W-1:0]  sel_addr;

  assign slot_free = !WriteEnable || !mem_stall;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= NREQ)
        sum = sum - NREQ;
      if (!gnt_any && req_valid[sum[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
    if (gnt_any)
      gnt_oh[gnt_idx] = 1'b1;
  end

  assign nxt_ptr = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  assign req_ready = (slot_free && reset_n) ? gnt_oh : '0;

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      WriteBus     <= '0;
      WriteAddress <= '0;
      WriteEnable  <= 1'b0;
      rr_ptr       <= '0;
    end else if (slot_free) begin
      if (gnt_any) begin
        WriteBus     <= sel_data;
        WriteAddress <= sel_addr;
        WriteEnable  <= 1'b1;
        rr_ptr       <= nxt_ptr;
      end else begin
        // Address deliberately kept; only the bus is cleared.
        WriteBus     <= '0;
        WriteEnable  <= 1'b0;
      end
    end
  end

  assign idle = !WriteEnable && !(|req_valid);

`ifdef WR_ARB_STATS_EN
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wr_cnt_q <= '0;
    else if (WriteEnable && !mem_stall)
      wr_cnt_q <= wr_cnt_q + 16'd1;
  end

  assign write_count = wr_cnt_q;
`else
  assign write_count = 16'h0000;
`endif

endmodule
